// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line writer.
// Holds the shrink mask table, FSM state enum and pixel-select helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Bit 15 of each entry corresponds to slot 0.
    localparam logic [15:0] SHRINK_MASK [16] = '{
        16'h0080, 16'h0880, 16'h0888, 16'h2888,
        16'h288A, 16'h2A8A, 16'h2AAA, 16'hAAAA,
        16'hAAEA, 16'hBAEA, 16'hBAEB, 16'hBBEB,
        16'hBBEF, 16'hFBEF, 16'hFBFF, 16'hFFFF
    };

    // Slot i picks pixel i, or pixel 15-i when flipped (~slot == 15-slot).
    function automatic logic [3:0] pix_sel(
        input logic [63:0] row,
        input logic [3:0]  slot,
        input logic        flip
    );
        logic [3:0] idx;
        idx = flip ? ~slot : slot;
        return row[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sprite_line_writer_rom.sv
// Combinational shrink code to 16-bit keep mask lookup.
// Ports: shrink_i (4-bit code), mask_o (keep mask, bit 15 = slot 0).
module shrink_mask_rom
    import sprite_pkg::*;
(
    input  logic [3:0]  shrink_i,
    output logic [15:0] mask_o
);

    assign mask_o = SHRINK_MASK[shrink_i];

endmodule

// File: rtl/sprite_line_writer.sv
// Walks one 16-pixel tile row and writes kept opaque pixels to a line buffer.
// Ports: CLK/RESET, START/READY load handshake, row attributes, WR_* port, BUSY, DONE.
module sprite_line_writer
    import sprite_pkg::*;
#(
    parameter int XW   = 9,
    parameter int PALW = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    output logic            READY,
    input  logic [63:0]     ROW,
    input  logic [PALW-1:0] PAL,
    input  logic [XW-1:0]   XPOS,
    input  logic            HFLIP,
    input  logic [3:0]      SHRINK,
    output logic            WR_EN,
    output logic [XW-1:0]   WR_ADDR,
    output logic [PALW+3:0] WR_DATA,
    input  logic            WR_READY,
    output logic            BUSY,
    output logic            DONE
);

    state_e            state_q, state_d;
    logic [3:0]        slot_q, slot_d;
    logic [XW-1:0]     addr_q, addr_d;
    logic [63:0]       row_q, row_d;
    logic [PALW-1:0]   pal_q, pal_d;
    logic              flip_q, flip_d;
    logic [15:0]       mask_q, mask_d;
    logic              wr_en_q, wr_en_d;
    logic [XW-1:0]     wr_addr_q, wr_addr_d;
    logic [PALW+3:0]   wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [15:0]       cap_mask;
    logic              consume;
    logic              kept_cur;
    logic              pres;
    logic [3:0]        color;

    shrink_mask_rom u_rom (
        .shrink_i (SHRINK),
        .mask_o   (cap_mask)
    );

    // Outputs are registered, so the next slot's write is precomputed
    // from the next-state values whenever a slot advances.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        addr_d    = addr_q;
        row_d     = row_q;
        pal_d     = pal_q;
        flip_d    = flip_q;
        mask_d    = mask_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pres      = 1'b0;
        color     = 4'd0;

        // Only a presented write can stall the slot.
        consume  = !wr_en_q || WR_READY;
        kept_cur = mask_q[~slot_q];

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                    row_d   = ROW;
                    pal_d   = PAL;
                    flip_d  = HFLIP;
                    mask_d  = cap_mask;
                    slot_d  = 4'd0;
                    addr_d  = XPOS;
                    pres    = 1'b1;
                end
            end
            ST_RUN: begin
                if (consume) begin
                    if (slot_q == 4'd15) begin
                        state_d = ST_DONE;
                        wr_en_d = 1'b0;
                    end else begin
                        slot_d = slot_q + 4'd1;
                        addr_d = addr_q + XW'(kept_cur);
                        pres   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
            end
        endcase

        if (pres) begin
            color     = pix_sel(row_d, slot_d, flip_d);
            wr_en_d   = mask_d[~slot_d] && (color != 4'd0);
            wr_addr_d = addr_d;
            wr_data_d = {pal_d, color};
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            pal_q     <= '0;
            flip_q    <= 1'b0;
            mask_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            pal_q     <= pal_d;
            flip_q    <= flip_d;
            mask_q    <= mask_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign READY   = ready_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign WR_EN   = wr_en_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_sprite_line_writer.sv
// Directed self-checking bench for sprite_line_writer.
// Logs completed writes and DONE pulses, compares against hand-computed values.
module tb_sprite_line_writer;

    localparam int XW   = 9;
    localparam int PALW = 8;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            START = 1'b0;
    logic            READY;
    logic [63:0]     ROW = '0;
    logic [PALW-1:0] PAL = '0;
    logic [XW-1:0]   XPOS = '0;
    logic            HFLIP = 1'b0;
    logic [3:0]      SHRINK = '0;
    logic            WR_EN;
    logic [XW-1:0]   WR_ADDR;
    logic [PALW+3:0] WR_DATA;
    logic            WR_READY = 1'b1;
    logic            BUSY;
    logic            DONE;

    sprite_line_writer #(.XW(XW), .PALW(PALW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .READY    (READY),
        .ROW      (ROW),
        .PAL      (PAL),
        .XPOS     (XPOS),
        .HFLIP    (HFLIP),
        .SHRINK   (SHRINK),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_READY (WR_READY),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    logic [XW-1:0]   waddr[$];
    logic [PALW+3:0] wdata[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (WR_EN && WR_READY) begin
                waddr.push_back(WR_ADDR);
                wdata.push_back(WR_DATA);
            end
            if (DONE) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (START && READY) acc_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_row(input logic [63:0] r, input logic [7:0] p,
                           input logic [8:0] x, input logic f,
                           input logic [3:0] s);
        waddr.delete();
        wdata.delete();
        @(posedge CLK);
        #1;
        ROW = r; PAL = p; XPOS = x; HFLIP = f; SHRINK = s;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        int c0;
        bit ok;
        c0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(posedge CLK);
            if (done_cnt != c0) ok = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        lat = done_cyc - acc_cyc;
        #1;
    endtask

    logic [63:0] row_a;
    int lat;
    int c0;

    initial begin
        for (int n = 0; n < 15; n++) row_a[4*n +: 4] = 4'(n + 1);
        row_a[63:60] = 4'd0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_wren", 32'(WR_EN), 32'd0);
        chk("rst_addr", 32'(WR_ADDR), 32'd0);
        chk("rst_data", 32'(WR_DATA), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Full width, no stalls.
        run_row(row_a, 8'h3C, 9'h010, 1'b0, 4'd15);
        @(negedge CLK);
        chk("full_busy", 32'(BUSY), 32'd1);
        chk("full_ready", 32'(READY), 32'd0);
        wait_done("full", lat);
        chk("full_lat", 32'(lat), 32'd17);
        @(negedge CLK);
        chk("full_ready_after", 32'(READY), 32'd1);
        chk("full_nwr", 32'(waddr.size()), 32'd15);
        for (int i = 0; i < 15 && i < waddr.size(); i++) begin
            chk("full_addr", 32'(waddr[i]), 32'(9'h010 + i));
            chk("full_data", 32'(wdata[i]), 32'(12'h3C0 + i + 1));
        end

        // Minimum shrink keeps only slot 8.
        run_row(64'h5555555555555555, 8'h12, 9'h100, 1'b0, 4'd0);
        wait_done("min", lat);
        chk("min_lat", 32'(lat), 32'd17);
        chk("min_nwr", 32'(waddr.size()), 32'd1);
        if (waddr.size() > 0) begin
            chk("min_addr", 32'(waddr[0]), 32'h100);
            chk("min_data", 32'(wdata[0]), 32'h125);
        end

        // Flip with half shrink: even slots, odd colors descending.
        run_row(64'hFEDCBA9876543210, 8'h77, 9'h0A0, 1'b1, 4'd7);
        wait_done("flip", lat);
        chk("flip_nwr", 32'(waddr.size()), 32'd8);
        for (int i = 0; i < 8 && i < waddr.size(); i++) begin
            chk("flip_addr", 32'(waddr[i]), 32'(9'h0A0 + i));
            chk("flip_data", 32'(wdata[i]), 32'(12'h770 + 15 - 2 * i));
        end

        // Stall the first write for three cycles.
        WR_READY = 1'b0;
        run_row(row_a, 8'h3C, 9'h020, 1'b0, 4'd15);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("stall_wren", 32'(WR_EN), 32'd1);
            chk("stall_addr", 32'(WR_ADDR), 32'h020);
            chk("stall_data", 32'(WR_DATA), 32'h3C1);
            @(posedge CLK);
            #1;
        end
        WR_READY = 1'b1;
        wait_done("stall", lat);
        chk("stall_lat", 32'(lat), 32'd20);
        chk("stall_nwr", 32'(waddr.size()), 32'd15);
        if (waddr.size() == 15) begin
            chk("stall_first", 32'(waddr[0]), 32'h020);
            chk("stall_first_d", 32'(wdata[0]), 32'h3C1);
            chk("stall_last", 32'(waddr[14]), 32'h02E);
            chk("stall_last_d", 32'(wdata[14]), 32'h3CF);
        end

        // Address wrap.
        run_row(64'hAAAAAAAAAAAAAAAA, 8'h01, 9'h1FC, 1'b0, 4'd15);
        wait_done("wrap", lat);
        chk("wrap_lat", 32'(lat), 32'd17);
        chk("wrap_nwr", 32'(waddr.size()), 32'd16);
        for (int i = 0; i < 16 && i < waddr.size(); i++) begin
            chk("wrap_addr", 32'(waddr[i]), 32'((9'h1FC + i) & 9'h1FF));
        end

        // Reset mid-row while slot 6 is presented.
        c0 = done_cnt;
        run_row(64'h7777777777777777, 8'h44, 9'h040, 1'b0, 4'd15);
        repeat (6) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("mrst_ready", 32'(READY), 32'd1);
        chk("mrst_busy", 32'(BUSY), 32'd0);
        chk("mrst_wren", 32'(WR_EN), 32'd0);
        chk("mrst_done", 32'(DONE), 32'd0);
        chk("mrst_nwr", 32'(waddr.size()), 32'd6);
        repeat (25) @(posedge CLK);
        chk("mrst_no_done", 32'(done_cnt - c0), 32'd0);

        // START during RUN is ignored.
        c0 = done_cnt;
        run_row(64'h3333333333333333, 8'h55, 9'h080, 1'b0, 4'd15);
        repeat (3) @(posedge CLK);
        #1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done("busy_start", lat);
        chk("busy_start_lat", 32'(lat), 32'd17);
        repeat (25) @(posedge CLK);
        chk("busy_start_ndone", 32'(done_cnt - c0), 32'd1);
        chk("busy_start_nwr", 32'(waddr.size()), 32'd16);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_line_writer.md
# sprite_line_writer

Per-sprite-tile-row write sequencer for the sprite line buffers. It accepts one 16-pixel, 4bpp tile row with palette, X position, flip and horizontal shrink. It walks the 16 pixel slots at one slot per cycle and uses the shrink mask to drop pixels. Kept, non-transparent pixels are written into the line-buffer write port at consecutive X addresses. It sits between the sprite fetch pipeline (upstream) and the line-buffer port arbiter (downstream, shared with line clearing).

## Interface
Parameters:
- XW, 9, X address width; line buffer is 2^XW entries and addressing wraps.
- PALW, 8, palette index width.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  load request; sampled only when READY=1.
- READY  out  1  high in IDLE; START accepted on the same edge.
- ROW  in  64  tile row, pixel n = ROW[4n+3:4n], n=0 leftmost unflipped.
- PAL  in  PALW  palette index.
- XPOS  in  XW  screen X of first kept pixel.
- HFLIP  in  1  horizontal flip.
- SHRINK  in  4  horizontal shrink code, 15 = full width.
- WR_EN  out  1  line-buffer write strobe.
- WR_ADDR  out  XW  write address.
- WR_DATA  out  PALW+4  {palette, color}.
- WR_READY  in  1  arbiter grant; write completes on an edge where WR_EN and WR_READY are both high.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse after the last slot.

## Operation
- **Capture.** On an edge with START=1 and READY=1, the block registers ROW, PAL, XPOS, HFLIP and mask=SHRINK_MASK[SHRINK]. It also sets slot=0 and addr=XPOS, then goes to RUN.
- **Shrink mask.** 16 bits; bit 15 corresponds to slot 0. Mask values by code:
  - 0=0x0080, 1=0x0880, 2=0x0888, 3=0x2888
  - 4=0x288A, 5=0x2A8A, 6=0x2AAA, 7=0xAAAA
  - 8=0xAAEA, 9=0xBAEA, 10=0xBAEB, 11=0xBBEB
  - 12=0xBBEF, 13=0xFBEF, 14=0xFBFF, 15=0xFFFF
  - Kept pixel count = SHRINK+1.
- **Pixel selection.** Slot i selects pixel i, or pixel 15−i when HFLIP=1. The mask is always indexed by slot, independent of flip.
- **RUN, per cycle, current slot:**
  - Mask bit 0: slot consumed, addr unchanged, WR_EN=0.
  - Mask bit 1 and color 0 (transparent): slot consumed, addr+1, WR_EN=0.
  - Mask bit 1 and color ≠ 0: WR_EN=1, WR_ADDR=addr, WR_DATA={PAL,color}.
    - If WR_READY=1: slot consumed and addr+1.
    - If WR_READY=0: stall; all registers hold and WR_EN/WR_ADDR/WR_DATA stay stable until granted.
- **Finish.** After slot 15 is consumed, go to DONE for one cycle (DONE=1), then IDLE.
- **Arithmetic.** addr increments modulo 2^XW, so 0x1FF+1 = 0x000. Writes across the wrap are legal.
- **States.** IDLE → RUN (accepted START) → DONE → IDLE. START is ignored outside IDLE and is not queued.
- **Reset.** RESET forces IDLE from any state, including mid-row or stalled.
  - All outputs deasserted: READY=1, BUSY=0, DONE=0, WR_EN=0, WR_ADDR=0, WR_DATA=0.
  - An in-flight write is abandoned.

## Timing
- Accept edge T0: BUSY=1 from T0+1; slot 0 is presented in cycle T0+1.
- With no stalls, slots occupy cycles T0+1..T0+16, DONE=1 in T0+17, and READY=1 in T0+18.
- Total latency is 17 cycles + number of stall cycles, regardless of SHRINK.
- WR_* outputs are registered-state driven; WR_EN never depends combinationally on WR_READY.
- Back-to-back rows: the next accept is possible on the edge ending the first READY cycle, so the accept-to-accept pitch is 18 cycles.

## Structure
- Package `sprite_pkg`: SHRINK_MASK[16] constant, state enum (IDLE/RUN/DONE), and a pixel-select helper function (slot, flip → nibble).
- One natural sub-module: `shrink_mask_rom`, combinational SHRINK → 16-bit mask, instantiated once at capture.
- Core FSM, slot counter (4 bits) and address counter stay in the top module.

## Test plan
- **Full width, no stalls:** SHRINK=15, XPOS=0x010, HFLIP=0, ROW pixels n=n+1 except pixel 15=0, PAL=0x3C, WR_READY=1 → 15 writes at 0x010..0x01E with data 0x3C1..0x3CF; no write for pixel 15; DONE at T0+17.
- **Minimum shrink:** SHRINK=0, all pixels 0x5 → exactly one write, from slot 8, at XPOS; DONE at T0+17.
- **Flip plus shrink:** SHRINK=7, HFLIP=1, pixel n=n → writes only on even slots at XPOS..XPOS+7 with colors 15,13,11,9,7,5,3,1.
- **Stall:** WR_READY held low for 3 cycles on the first write → WR_EN/WR_ADDR/WR_DATA stable for 3 cycles, DONE delayed to T0+20, no write lost or duplicated.
- **Wrap:** XPOS=0x1FC, SHRINK=15, all pixels nonzero → addresses 0x1FC..0x1FF then 0x000..0x00B.
- **Reset and START-while-busy:** RESET asserted mid-row at slot 6 → next cycle IDLE, READY=1, WR_EN=0, no DONE pulse. START pulsed during RUN → ignored, exactly one DONE per accepted START.
